fifo_packet_reader: RTL

//  Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain.

---
 rtl/fifo_packet_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_packet_reader.sv
// Read-domain consumer for the async FIFO. It parses length-prefixed packets
// and presents the payload as a valid/ready stream through a 2-entry skid buffer.
module fifo_packet_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  zero_hdr
);

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] remaining_nxt;

    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_count;

    logic                  push;
    logic                  push_last;
    logic                  pop;
    logic [2:0]            credit_sum;

    // A pop is only issued when the buffer can absorb the word it returns,
    // counting the word already in flight from the FIFO.
    assign credit_sum = {1'b0, buf_count} + {2'b00, in_flight};
    assign fifo_r_en  = !rrst && !fifo_empty && (credit_sum < 3'd2);

    assign m_valid = (buf_count != 2'd0);
    assign m_data  = buf_data[rd_ptr];
    assign m_last  = buf_last[rd_ptr];
    assign pop     = m_valid && m_ready;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= HDR;
            remaining <= '0;
            in_flight <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            in_flight <= fifo_r_en;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        push          = 1'b0;
        push_last     = 1'b0;
        zero_hdr      = 1'b0;
        if (in_flight) begin
            case (state)
                HDR: begin
                    if (fifo_data == '0) begin
                        zero_hdr = 1'b1;
                    end else begin
                        remaining_nxt = fifo_data;
                        state_nxt     = PAY;
                    end
                end
                PAY: begin
                    push          = 1'b1;
                    push_last     = (remaining == DATA_WIDTH'(1));
                    remaining_nxt = remaining - DATA_WIDTH'(1);
                    if (push_last) begin
                        state_nxt = HDR;
                    end
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_count   <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= fifo_data;
                buf_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            pkt_count <= '0;
        end else if (pop && m_last) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule
